// File: rtl/cv32e40p_ldm_pkg.sv
// Shared types and default constants for the LDM response sequencer.
// The state encoding is fixed because state_o exposes it for debug.
package cv32e40p_ldm_pkg;

   typedef enum logic [2:0] {
      LDM_DISARMED = 3'd0,
      LDM_CLEAR    = 3'd1,
      LDM_ARMED    = 3'd2,
      LDM_ALERT    = 3'd3,
      LDM_ESCALATE = 3'd4,
      LDM_LOCKOUT  = 3'd5
   } ldm_ctrl_state_e;

   localparam int unsigned LDM_ACK_TIMEOUT      = 32'd64;
   localparam int unsigned LDM_RST_PULSE_CYCLES = 32'd8;
   localparam int unsigned LDM_MAX_ESCALATIONS  = 32'd3;

   function automatic int unsigned ldm_max(input int unsigned a, input int unsigned b);
      ldm_max = (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cv32e40p_ldm_timer.sv
// Loadable down-counter that holds at zero; used for the ack window and the
// reset pulse length of the LDM sequencer.
module cv32e40p_ldm_timer #(
   parameter int unsigned W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         one_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   // next count: load has priority, decrement saturates at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != {W{1'b0}})) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign one_o  = (cnt_q == W'(1));
   assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/cv32e40p_ldm_controller.sv
// LDM response sequencer: arms the detector, raises an alert on alarm,
// escalates to core reset requests when unacknowledged, and locks out.
module cv32e40p_ldm_controller
   import cv32e40p_ldm_pkg::*;
#(
   parameter  int unsigned ACK_TIMEOUT      = LDM_ACK_TIMEOUT,
   parameter  int unsigned RST_PULSE_CYCLES = LDM_RST_PULSE_CYCLES,
   parameter  int unsigned MAX_ESCALATIONS  = LDM_MAX_ESCALATIONS,
   localparam int unsigned ESC_W = $clog2(MAX_ESCALATIONS + 1),
   localparam int unsigned TMR_W = $clog2(ldm_max(ACK_TIMEOUT, RST_PULSE_CYCLES) + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm_i,
   input  logic             alarm_i,
   input  logic             irq_ack_i,
   output logic             det_clear_o,
   output logic             irq_o,
   output logic             core_rst_req_o,
   output logic             fault_o,
   output logic [ESC_W-1:0] esc_count_o,
   output logic [2:0]       state_o
);

   ldm_ctrl_state_e  state_d, state_q;
   logic [ESC_W-1:0] esc_count_d, esc_count_q;
   logic             det_clear_d, det_clear_q;
   logic             irq_d, irq_q;
   logic             core_rst_req_d, core_rst_req_q;
   logic             fault_d, fault_q;

   logic             tmr_load_s;
   logic [TMR_W-1:0] tmr_load_val_s;
   logic             tmr_dec_s;
   logic             tmr_one_s;
   logic             tmr_zero_s;
   logic             tmr_done_s;

   cv32e40p_ldm_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_load_val_s),
      .dec_i      (tmr_dec_s),
      .one_o      (tmr_one_s),
      .zero_o     (tmr_zero_s)
   );

   // A zero count can only occur in a timed state after a glitch; end the phase then too.
   assign tmr_done_s = tmr_one_s | tmr_zero_s;

   // next state, escalation count, timer control and output decode
   always_comb begin
      state_d        = state_q;
      esc_count_d    = esc_count_q;
      tmr_load_s     = 1'b0;
      tmr_load_val_s = {TMR_W{1'b0}};
      tmr_dec_s      = 1'b0;
      case (state_q)
         LDM_DISARMED: begin
            if (arm_i) begin
               state_d     = LDM_CLEAR;
               esc_count_d = {ESC_W{1'b0}};
            end else begin
               state_d = LDM_DISARMED;
            end
         end
         LDM_CLEAR: begin
            state_d = arm_i ? LDM_ARMED : LDM_DISARMED;
         end
         LDM_ARMED: begin
            if (!arm_i) begin
               state_d = LDM_DISARMED;
            end else if (alarm_i) begin
               state_d        = LDM_ALERT;
               tmr_load_s     = 1'b1;
               tmr_load_val_s = TMR_W'(ACK_TIMEOUT);
            end else begin
               state_d = LDM_ARMED;
            end
         end
         LDM_ALERT: begin
            if (!arm_i) begin
               state_d = LDM_DISARMED;
            end else if (irq_ack_i) begin
               state_d = LDM_CLEAR;
            end else if (tmr_done_s) begin
               state_d        = LDM_ESCALATE;
               tmr_load_s     = 1'b1;
               tmr_load_val_s = TMR_W'(RST_PULSE_CYCLES);
               if (esc_count_q != ESC_W'(MAX_ESCALATIONS)) begin
                  esc_count_d = esc_count_q + ESC_W'(1);
               end else begin
                  esc_count_d = esc_count_q;
               end
            end else begin
               tmr_dec_s = 1'b1;
            end
         end
         LDM_ESCALATE: begin
            if (tmr_done_s) begin
               state_d = (esc_count_q == ESC_W'(MAX_ESCALATIONS)) ? LDM_LOCKOUT : LDM_ARMED;
            end else begin
               tmr_dec_s = 1'b1;
            end
         end
         LDM_LOCKOUT: begin
            state_d = LDM_LOCKOUT;
         end
         default: begin
            state_d = LDM_DISARMED;
         end
      endcase

      det_clear_d    = (state_d == LDM_CLEAR) || (state_d == LDM_ESCALATE) || (state_d == LDM_LOCKOUT);
      irq_d          = (state_d == LDM_ALERT);
      core_rst_req_d = (state_d == LDM_ESCALATE) || (state_d == LDM_LOCKOUT);
      fault_d        = (state_d == LDM_LOCKOUT);
   end

   // state, escalation count and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= LDM_DISARMED;
         esc_count_q    <= {ESC_W{1'b0}};
         det_clear_q    <= 1'b0;
         irq_q          <= 1'b0;
         core_rst_req_q <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         esc_count_q    <= esc_count_d;
         det_clear_q    <= det_clear_d;
         irq_q          <= irq_d;
         core_rst_req_q <= core_rst_req_d;
         fault_q        <= fault_d;
      end
   end

   assign det_clear_o    = det_clear_q;
   assign irq_o          = irq_q;
   assign core_rst_req_o = core_rst_req_q;
   assign fault_o        = fault_q;
   assign esc_count_o    = esc_count_q;
   assign state_o        = state_q;

endmodule
